operand_sequencer: RTL
======================

Name: operand_sequencer

Overview:
- Upstream stage of the 8-bit ALU: turns raw slide-switch data and two push-buttons into a stable operand pair (reg_a, reg_b) for the ALU's A/B inputs.
- Synchronises and debounces the buttons, then steps through a load FSM: first press loads A, second press loads B.
- Presents the pair to the downstream consumer with a valid/ready handshake.
- Runs on the prescaled system clock.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a button level change is accepted (minimum 1).
- SYNC_STAGES, 2: flip-flop stages in each input synchroniser (minimum 2).

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  asynchronous, active-high reset
- sw_data  input  8  raw switch operand value
- btn_load  input  1  raw load push-button, active-high, bouncy
- btn_clear  input  1  raw clear push-button, active-high, bouncy
- op_ready  input  1  downstream has consumed the operand pair
- reg_a  output  8  operand A to ALU
- reg_b  output  8  operand B to ALU
- operands_valid  output  1  reg_a/reg_b form a complete, unconsumed pair
- state  output  2  00 WAIT_A, 01 WAIT_B, 10 READY (11 unused)
- load_count  output  8  completed operand pairs, wraps

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset values: reg_a=0, reg_b=0, operands_valid=0, state=WAIT_A, load_count=0. Reset also clears synchronisers, debounce counters, debounced levels and edge registers.
- Reset is honoured mid-debounce or mid-sequence with no residual pulse after release.
- Synchronisers:
  - btn_load, btn_clear and all 8 sw_data bits each pass through a SYNC_STAGES-deep flop chain.
  - sw_data is sampled only from the synchronised copy.
- Debounce (per button):
  - Counter of width clog2(DEBOUNCE_CYCLES+1).
  - While the synchronised level differs from the debounced level, the counter increments. Otherwise it is held at 0.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced level flips and the counter returns to 0.
  - Any return to the old level before that resets the counter to 0.
- Edge detect:
  - load_pulse/clear_pulse are one-cycle, internal, and fire on a 0->1 transition of the debounced level.
  - Releases (1->0) produce no pulse.
- Latency: a raw press held stable from cycle 0 produces load_pulse in cycle SYNC_STAGES+DEBOUNCE_CYCLES+1. Register updates are visible one cycle later.
- FSM, evaluated on pulse cycles:
  - WAIT_A + load_pulse: reg_a <= synced sw_data, go to WAIT_B.
  - WAIT_B + load_pulse: reg_b <= synced sw_data, go to READY, operands_valid <= 1, load_count += 1 (255 wraps to 0).
  - READY: operands_valid held at 1 with reg_a/reg_b stable until handshake.
  - READY + op_ready=1: operands_valid <= 0, go to WAIT_A. reg_a/reg_b keep their values.
  - READY + load_pulse (no op_ready): pair is abandoned. reg_a <= sw_data, reg_b unchanged, operands_valid <= 0, go to WAIT_B.
  - READY + load_pulse + op_ready in the same cycle: the handshake completes, then the load applies as from WAIT_A. reg_a <= sw_data, go to WAIT_B, operands_valid <= 0.
  - op_ready outside READY: ignored.
- Clear:
  - clear_pulse in any state sets reg_a=0, reg_b=0, operands_valid=0, state=WAIT_A. load_count is unchanged.
  - clear_pulse and load_pulse in the same cycle: clear wins and the load is discarded.
- reg_a/reg_b change only on the events above. They never glitch between events.

Test Plan (DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Reset then idle: all outputs 0, state=00. Assert rst mid-sequence (state=01): outputs return to reset values asynchronously within the same cycle.
- Two clean presses: sw_data=0x3C, btn_load high for 10 cycles, low; then sw_data=0xA5, second press.
  - After the first press: state=01 and reg_a=0x3C at cycle 8.
  - After the second press: reg_b=0xA5, state=10, operands_valid=1, load_count=1.
- Bounce rejection: btn_load toggles every 2 cycles for 20 cycles, then goes low -> no load, state stays 00. A 3-cycle glitch also produces no load.
- Handshake: with operands_valid=1, hold op_ready=0 for 5 cycles -> valid stays 1 and regs are stable. Pulse op_ready=1 -> next cycle valid=0, state=00, reg_a/reg_b retained.
- Clear priority: in WAIT_B (reg_a=0x11), press btn_load and btn_clear simultaneously -> reg_a=0, reg_b=0, state=00, load_count unchanged.
- Counter wrap: complete 256 handshaken pairs -> load_count returns to 0x00 after the 256th. Abandon-in-READY press -> state=01, valid=0, count not incremented.

Source files
------------

// File: rtl/operand_sequencer.sv
// operand_sequencer: synchronises and debounces the load/clear buttons, loads
// the switch value into A then B, and offers the pair through valid/ready.
//   clk, rst       : clock, asynchronous active-high reset
//   sw_data        : raw switch operand value
//   btn_load       : raw load button (bouncy)
//   btn_clear      : raw clear button (bouncy)
//   op_ready       : consumer has taken the operand pair
//   reg_a, reg_b   : operand pair to the ALU
//   operands_valid : reg_a/reg_b hold a complete, unconsumed pair
//   state          : 00 WAIT_A, 01 WAIT_B, 10 READY
//   load_count     : completed pairs, wrapping
module operand_sequencer #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] sw_data,
    input  logic       btn_load,
    input  logic       btn_clear,
    input  logic       op_ready,
    output logic [7:0] reg_a,
    output logic [7:0] reg_b,
    output logic       operands_valid,
    output logic [1:0] state,
    output logic [7:0] load_count
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEBOUNCE_CYCLES);
    localparam logic [1:0] WAIT_A = 2'b00;
    localparam logic [1:0] WAIT_B = 2'b01;
    localparam logic [1:0] READY  = 2'b10;

    logic [SYNC_STAGES-1:0]      load_sync, clear_sync;
    logic [SYNC_STAGES-1:0][7:0] sw_sync;
    logic [1:0]                  btn_sync, deb, deb_q;
    logic [CW-1:0]               cnt [2];
    logic                        load_pulse, clear_pulse;
    logic [7:0]                  sw_now;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            load_sync  <= '0;
            clear_sync <= '0;
            sw_sync    <= '0;
        end else begin
            load_sync  <= {load_sync[SYNC_STAGES-2:0], btn_load};
            clear_sync <= {clear_sync[SYNC_STAGES-2:0], btn_clear};
            sw_sync    <= {sw_sync[SYNC_STAGES-2:0], sw_data};
        end
    end

    assign btn_sync = {clear_sync[SYNC_STAGES-1], load_sync[SYNC_STAGES-1]};
    assign sw_now   = sw_sync[SYNC_STAGES-1];

    // A level change is accepted only if it is still present when the
    // counter has reached DEBOUNCE_CYCLES; any return to the old level restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb    <= '0;
            deb_q  <= '0;
            cnt[0] <= '0;
            cnt[1] <= '0;
        end else begin
            deb_q <= deb;
            for (int i = 0; i < 2; i++) begin
                if (btn_sync[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_MAX) begin
                    deb[i] <= btn_sync[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign load_pulse  = deb[0] & ~deb_q[0];
    assign clear_pulse = deb[1] & ~deb_q[1];

    // In READY a load always restarts from A: with op_ready the handshake
    // completes first, without it the pair is abandoned; both end in WAIT_B.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_a          <= '0;
            reg_b          <= '0;
            operands_valid <= 1'b0;
            state          <= WAIT_A;
            load_count     <= '0;
        end else if (clear_pulse) begin
            reg_a          <= '0;
            reg_b          <= '0;
            operands_valid <= 1'b0;
            state          <= WAIT_A;
        end else begin
            case (state)
                WAIT_A: begin
                    if (load_pulse) begin
                        reg_a <= sw_now;
                        state <= WAIT_B;
                    end
                end
                WAIT_B: begin
                    if (load_pulse) begin
                        reg_b          <= sw_now;
                        state          <= READY;
                        operands_valid <= 1'b1;
                        load_count     <= load_count + 8'd1;
                    end
                end
                READY: begin
                    if (load_pulse) begin
                        reg_a          <= sw_now;
                        state          <= WAIT_B;
                        operands_valid <= 1'b0;
                    end else if (op_ready) begin
                        state          <= WAIT_A;
                        operands_valid <= 1'b0;
                    end
                end
                default: begin
                    state          <= WAIT_A;
                    operands_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
